// File: rtl/k580ww55_hs_pkg.sv
// k580ww55_hs shared definitions
// mode-word fields, reset mode, port C handshake pins, addresses
package k580ww55_hs_pkg;

  typedef enum logic [1:0] {
    ADDR_A   = 2'd0,
    ADDR_B   = 2'd1,
    ADDR_C   = 2'd2,
    ADDR_CTL = 2'd3
  } addr_e;

  localparam logic [7:0] MODE_RST = 8'h9B;

  localparam int M_SET   = 7;
  localparam int M_AM_HI = 6;
  localparam int M_AM_LO = 5;
  localparam int M_A_IN  = 4;
  localparam int M_CH_IN = 3;
  localparam int M_B_M1  = 2;
  localparam int M_B_IN  = 1;
  localparam int M_CL_IN = 0;

  localparam int PC_INTR_A = 3;
  localparam int PC_STB_A  = 4;
  localparam int PC_IBF_A  = 5;
  localparam int PC_ACK_A  = 6;
  localparam int PC_OBF_A  = 7;
  localparam int PC_INTR_B = 0;
  localparam int PC_HS_B   = 1;
  localparam int PC_STB_B  = 2;

  function automatic logic a_mode1(input logic [6:0] m);
    return m[M_AM_HI:M_AM_LO] == 2'b01;
  endfunction

endpackage

// File: rtl/k580ww55_hs_chan.sv
// k580ww55_hs handshake channel
// strobe sync, edge detect, IBF/OBF/INTR/INTE flags, input latch
module k580ww55_hs_chan #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         mode1,
  input  logic         dir_in,
  input  logic         stb,
  input  logic [W-1:0] din,
  input  logic         wr,
  input  logic         rd_start,
  input  logic         rd_end,
  input  logic         inte_wr,
  input  logic         inte_val,
  output logic         ibf,
  output logic         obf,
  output logic         intr,
  output logic         inte,
  output logic [W-1:0] dlat
);

  logic s1, s2, s3;
  logic fall, rise;

  assign fall = s3 & ~s2;
  assign rise = ~s3 & s2;

  // two-flop synchroniser plus one delay flop for edge detect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= stb;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // handshake flags; a new strobe beats a read end, a write beats ACK
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ibf  <= 1'b0;
      obf  <= 1'b1;
      intr <= 1'b0;
      inte <= 1'b0;
      dlat <= '0;
    end else if (clr) begin
      ibf  <= 1'b0;
      obf  <= 1'b1;
      intr <= 1'b0;
      inte <= 1'b0;
      dlat <= '0;
    end else begin
      if (inte_wr) inte <= inte_val;
      if (mode1 && dir_in) begin
        if (fall) begin
          dlat <= din;
          ibf  <= 1'b1;
        end else if (rd_end) begin
          ibf <= 1'b0;
        end
        if (rd_start) intr <= 1'b0;
        else if (rise && ibf && inte) intr <= 1'b1;
      end
      if (mode1 && !dir_in) begin
        if (wr) begin
          obf  <= 1'b0;
          intr <= 1'b0;
        end else begin
          if (fall) obf <= 1'b1;
          if (rise && inte) intr <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/k580ww55_hs.sv
// k580ww55_hs top: 8255-style PPI with mode0/mode1 ports A and B
// port C carries handshake status for mode1 channels
module k580ww55_hs
  import k580ww55_hs_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [1:0]   addr,
  input  logic         we_n,
  input  logic         rd_n,
  input  logic [W-1:0] idata,
  output logic [W-1:0] odata,
  input  logic [W-1:0] ipa,
  input  logic [W-1:0] ipb,
  output logic [W-1:0] opa,
  output logic [W-1:0] opb,
  output logic         oea,
  output logic         oeb,
  input  logic [7:0]   ipc,
  output logic [7:0]   opc,
  output logic [7:0]   oec
);

  logic [6:0]   mode;
  logic [W-1:0] opa_q, opb_q;
  logic [7:0]   opc_q;
  logic [7:0]   c_rd;
  logic         wr_a, wr_b, wr_c, wr_ctl;
  logic         mode_wr, bsr_wr;
  logic [2:0]   bsr_bit;
  logic         a_m1, a_in, b_m1, b_in;
  logic         rd_a, rd_b, rd_a_q, rd_b_q;
  logic         stb_a, inte_wr_a, inte_wr_b;
  logic         ibf_a, obf_a, intr_a, inte_a;
  logic         ibf_b, obf_b, intr_b, inte_b;
  logic [W-1:0] lat_a, lat_b;

  assign wr_a    = !we_n && addr == ADDR_A;
  assign wr_b    = !we_n && addr == ADDR_B;
  assign wr_c    = !we_n && addr == ADDR_C;
  assign wr_ctl  = !we_n && addr == ADDR_CTL;
  assign mode_wr = wr_ctl && idata[M_SET];
  assign bsr_wr  = wr_ctl && !idata[M_SET];
  assign bsr_bit = idata[3:1];

  assign a_m1 = a_mode1(mode);
  assign a_in = mode[M_A_IN];
  assign b_m1 = mode[M_B_M1];
  assign b_in = mode[M_B_IN];

  assign rd_a = !rd_n && addr == ADDR_A;
  assign rd_b = !rd_n && addr == ADDR_B;

  assign stb_a = a_in ? ipc[PC_STB_A] : ipc[PC_ACK_A];

  assign inte_wr_a = bsr_wr &&
    ((a_in && bsr_bit == 3'(PC_STB_A)) ||
     (!a_in && bsr_bit == 3'(PC_ACK_A)));
  assign inte_wr_b = bsr_wr && bsr_bit == 3'(PC_STB_B);

  assign opa = opa_q;
  assign opb = opb_q;
  assign oea = !a_in;
  assign oeb = !b_in;

  // mode word, output latches and read-strobe history
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mode   <= MODE_RST[6:0];
      opa_q  <= '1;
      opb_q  <= '1;
      opc_q  <= 8'hFF;
      rd_a_q <= 1'b0;
      rd_b_q <= 1'b0;
    end else begin
      rd_a_q <= rd_a;
      rd_b_q <= rd_b;
      if (mode_wr) begin
        mode  <= idata[6:0];
        opa_q <= '0;
        opb_q <= '0;
        opc_q <= '0;
      end else begin
        if (wr_a) opa_q <= idata;
        if (wr_b) opb_q <= idata;
        if (wr_c) opc_q <= idata[7:0];
        if (bsr_wr) opc_q[bsr_bit] <= idata[0];
      end
    end
  end

  k580ww55_hs_chan #(.W(W)) u_chan_a (
    .clk      (clk),
    .reset    (reset),
    .clr      (mode_wr),
    .mode1    (a_m1),
    .dir_in   (a_in),
    .stb      (stb_a),
    .din      (ipa),
    .wr       (wr_a),
    .rd_start (rd_a && !rd_a_q),
    .rd_end   (rd_a_q && !rd_a),
    .inte_wr  (inte_wr_a),
    .inte_val (idata[0]),
    .ibf      (ibf_a),
    .obf      (obf_a),
    .intr     (intr_a),
    .inte     (inte_a),
    .dlat     (lat_a)
  );

  k580ww55_hs_chan #(.W(W)) u_chan_b (
    .clk      (clk),
    .reset    (reset),
    .clr      (mode_wr),
    .mode1    (b_m1),
    .dir_in   (b_in),
    .stb      (ipc[PC_STB_B]),
    .din      (ipb),
    .wr       (wr_b),
    .rd_start (rd_b && !rd_b_q),
    .rd_end   (rd_b_q && !rd_b),
    .inte_wr  (inte_wr_b),
    .inte_val (idata[0]),
    .ibf      (ibf_b),
    .obf      (obf_b),
    .intr     (intr_b),
    .inte     (inte_b),
    .dlat     (lat_b)
  );

  // port C pins, enables and read view with mode1 status overlaid
  always_comb begin
    opc  = opc_q;
    oec  = {{4{!mode[M_CH_IN]}}, {4{!mode[M_CL_IN]}}};
    c_rd[7:4] = mode[M_CH_IN] ? ipc[7:4] : opc_q[7:4];
    c_rd[3:0] = mode[M_CL_IN] ? ipc[3:0] : opc_q[3:0];
    if (a_m1) begin
      opc[PC_INTR_A]  = intr_a;
      oec[PC_INTR_A]  = 1'b1;
      c_rd[PC_INTR_A] = intr_a;
      if (a_in) begin
        opc[PC_IBF_A]  = ibf_a;
        oec[PC_IBF_A]  = 1'b1;
        oec[PC_STB_A]  = 1'b0;
        c_rd[PC_IBF_A] = ibf_a;
        c_rd[PC_STB_A] = inte_a;
      end else begin
        opc[PC_OBF_A]  = obf_a;
        oec[PC_OBF_A]  = 1'b1;
        oec[PC_ACK_A]  = 1'b0;
        c_rd[PC_OBF_A] = obf_a;
        c_rd[PC_ACK_A] = inte_a;
      end
    end
    if (b_m1) begin
      opc[PC_INTR_B]  = intr_b;
      opc[PC_HS_B]    = b_in ? ibf_b : obf_b;
      oec[PC_INTR_B]  = 1'b1;
      oec[PC_HS_B]    = 1'b1;
      oec[PC_STB_B]   = 1'b0;
      c_rd[PC_INTR_B] = intr_b;
      c_rd[PC_HS_B]   = b_in ? ibf_b : obf_b;
      c_rd[PC_STB_B]  = inte_b;
    end
  end

  // combinational read mux
  always_comb begin
    odata = '0;
    unique case (addr)
      ADDR_A:   odata = (a_m1 && a_in) ? lat_a : (a_in ? ipa : opa_q);
      ADDR_B:   odata = (b_m1 && b_in) ? lat_b : (b_in ? ipb : opb_q);
      ADDR_C:   odata[7:0] = c_rd;
      ADDR_CTL: odata = '0;
      default:  odata = '0;
    endcase
  end

endmodule

// File: tb/tb_k580ww55_hs.sv
// k580ww55_hs bench: directed stimulus, expectation queue,
// negedge monitor comparing against hand-computed values
module tb_k580ww55_hs;

  localparam int S_ODATA = 0;
  localparam int S_OPA   = 1;
  localparam int S_OPB   = 2;
  localparam int S_OPC   = 3;
  localparam int S_OEC   = 4;
  localparam int S_OEAB  = 5;

  typedef struct {
    string       name;
    int          sig;
    logic [15:0] exp;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [1:0] addr;
  logic       we_n;
  logic       rd_n;
  logic [7:0] idata;
  logic [7:0] odata;
  logic [7:0] ipa, ipb, opa, opb;
  logic       oea, oeb;
  logic [7:0] ipc, opc, oec;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  k580ww55_hs #(.W(8)) dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we_n  (we_n),
    .rd_n  (rd_n),
    .idata (idata),
    .odata (odata),
    .ipa   (ipa),
    .ipb   (ipb),
    .opa   (opa),
    .opb   (opb),
    .oea   (oea),
    .oeb   (oeb),
    .ipc   (ipc),
    .opc   (opc),
    .oec   (oec)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  function automatic logic [15:0] sample(int s);
    case (s)
      S_ODATA: return 16'(odata);
      S_OPA:   return 16'(opa);
      S_OPB:   return 16'(opb);
      S_OPC:   return 16'(opc);
      S_OEC:   return 16'(oec);
      S_OEAB:  return 16'({oea, oeb});
      default: return 16'hDEAD;
    endcase
  endfunction

  always @(negedge clk) begin
    while (q.size() != 0) begin
      automatic exp_t e = q.pop_front();
      automatic logic [15:0] a = sample(e.sig);
      checks++;
      if (a !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0h expected %0h", e.name, a, e.exp);
      end
    end
  end

  task automatic chk(input string n, input int s, input logic [15:0] e);
    exp_t x;
    x.name = n;
    x.sig  = s;
    x.exp  = e;
    q.push_back(x);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr_bus(input logic [1:0] a, input logic [7:0] d);
    addr  = a;
    idata = d;
    we_n  = 1'b0;
    cyc(1);
    we_n  = 1'b1;
  endtask

  task automatic rd_chk(input logic [1:0] a, input string n,
                        input logic [7:0] e);
    addr = a;
    rd_n = 1'b0;
    chk(n, S_ODATA, 16'(e));
    cyc(1);
    rd_n = 1'b1;
    cyc(1);
  endtask

  initial begin
    reset = 1'b1;
    addr  = 2'd0;
    we_n  = 1'b1;
    rd_n  = 1'b1;
    idata = 8'h00;
    ipa   = 8'hA5;
    ipb   = 8'h11;
    ipc   = 8'hFF;
    cyc(2);
    chk("rst_opa", S_OPA, 16'hFF);
    chk("rst_opb", S_OPB, 16'hFF);
    chk("rst_opc", S_OPC, 16'hFF);
    chk("rst_oec", S_OEC, 16'h00);
    chk("rst_oeab", S_OEAB, 16'h0);
    chk("rst_rd_a", S_ODATA, 16'hA5);
    cyc(1);
    reset = 1'b0;
    cyc(2);

    // mode0 all outputs, bit set/reset, port writes
    wr_bus(2'd3, 8'h80);
    chk("m0_opc_clr", S_OPC, 16'h00);
    chk("m0_opa_clr", S_OPA, 16'h00);
    chk("m0_oec", S_OEC, 16'hFF);
    chk("m0_oeab", S_OEAB, 16'h3);
    cyc(1);
    wr_bus(2'd3, 8'h07);
    chk("bsr_set3", S_OPC, 16'h08);
    cyc(1);
    wr_bus(2'd3, 8'h06);
    chk("bsr_clr3", S_OPC, 16'h00);
    cyc(1);
    wr_bus(2'd0, 8'h77);
    chk("m0_wr_a", S_OPA, 16'h77);
    cyc(1);
    rd_chk(2'd0, "m0_rd_a_latch", 8'h77);
    wr_bus(2'd2, 8'h81);
    chk("m0_wr_c", S_OPC, 16'h81);
    cyc(1);
    rd_chk(2'd2, "m0_rd_c", 8'h81);
    rd_chk(2'd3, "rd_ctl", 8'h00);
    wr_bus(2'd3, 8'h82);
    chk("m0_oeab_bin", S_OEAB, 16'h2);
    cyc(1);
    rd_chk(2'd1, "m0_rd_b_pins", 8'h11);

    // A mode1 output
    wr_bus(2'd3, 8'hA0);
    chk("m1o_opc", S_OPC, 16'h80);
    chk("m1o_oec", S_OEC, 16'hBF);
    cyc(1);
    wr_bus(2'd3, 8'h0D);
    cyc(1);
    rd_chk(2'd2, "m1o_stat_inte", 8'hC0);
    wr_bus(2'd0, 8'h5A);
    chk("m1o_opa", S_OPA, 16'h5A);
    chk("m1o_obf_low", S_OPC, 16'h40);
    cyc(1);
    ipc[6] = 1'b0;
    cyc(3);
    chk("m1o_ack_obf", S_OPC, 16'hC0);
    cyc(1);
    ipc[6] = 1'b1;
    cyc(3);
    chk("m1o_intr", S_OPC, 16'hC8);
    cyc(1);
    rd_chk(2'd2, "m1o_stat_intr", 8'hC8);

    // write A in the same cycle as the synchronised ACK fall
    ipc[6] = 1'b0;
    cyc(2);
    addr  = 2'd0;
    idata = 8'hC3;
    we_n  = 1'b0;
    cyc(1);
    we_n  = 1'b1;
    chk("race_obf_stays0", S_OPC, 16'h40);
    chk("race_opa", S_OPA, 16'hC3);
    cyc(1);
    ipc[6] = 1'b1;
    cyc(3);
    chk("race_ack_rise", S_OPC, 16'h48);
    cyc(1);

    // A mode1 input
    wr_bus(2'd3, 8'hB0);
    chk("m1i_oec", S_OEC, 16'hEF);
    chk("m1i_opc", S_OPC, 16'h00);
    chk("m1i_oeab", S_OEAB, 16'h1);
    cyc(1);
    wr_bus(2'd3, 8'h09);
    cyc(1);
    rd_chk(2'd2, "m1i_stat_inte", 8'h10);
    ipa = 8'h3C;
    ipc[4] = 1'b0;
    cyc(3);
    chk("m1i_ibf", S_OPC, 16'h30);
    cyc(1);
    ipc[4] = 1'b1;
    cyc(3);
    chk("m1i_intr", S_OPC, 16'h38);
    cyc(1);
    ipa  = 8'h00;
    addr = 2'd0;
    rd_n = 1'b0;
    chk("m1i_rd_latch", S_ODATA, 16'h3C);
    cyc(1);
    chk("m1i_rd_intr_clr", S_OPC, 16'h30);
    cyc(1);
    rd_n = 1'b1;
    cyc(1);
    chk("m1i_ibf_clr", S_OPC, 16'h10);
    cyc(1);

    // reset in the middle of a strobe
    ipa = 8'h66;
    ipc[4] = 1'b0;
    cyc(3);
    chk("mid_ibf", S_OPC, 16'h30);
    cyc(1);
    reset = 1'b1;
    chk("mid_rst_opc", S_OPC, 16'hFF);
    chk("mid_rst_opa", S_OPA, 16'hFF);
    chk("mid_rst_oeab", S_OEAB, 16'h0);
    cyc(2);
    reset = 1'b0;
    cyc(4);
    wr_bus(2'd3, 8'hB0);
    cyc(1);
    wr_bus(2'd3, 8'h09);
    chk("post_rst_flags", S_OPC, 16'h10);
    cyc(1);
    ipc[4] = 1'b1;
    cyc(4);
    chk("post_rst_no_intr", S_OPC, 16'h10);
    cyc(3);

    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
